// File: rtl/bram_frame_reader.sv
// Streams a contiguous BRAM frame (start address + length) onto a valid/ready stream.
// Optional trailing XOR checksum beat when BRAM_READER_CHECKSUM_EN is defined.
module bram_frame_reader #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] start_addr,
  input  logic [ADDRESS_WIDTH:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0]    bram_data,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int RW = ADDRESS_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
`ifdef BRAM_READER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [RW-1:0]         rem_q, rem_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  capture;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d  = start_addr;
          rem_d  = length;
          csum_d = '0;
          if (length != '0) begin
            state_d = S_LOAD;
          end else begin
`ifdef BRAM_READER_CHECKSUM_EN
            state_d = S_CSUM;
            data_d  = '0;
            valid_d = 1'b1;
            last_d  = 1'b1;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
      S_LOAD: capture = 1'b1;
      S_SEND: begin
        if (m_ready) begin
          if (rem_q != '0) begin
            capture = 1'b1;
          end else begin
`ifdef BRAM_READER_CHECKSUM_EN
            state_d = S_CSUM;
            data_d  = csum_q;
            valid_d = 1'b1;
            last_d  = 1'b1;
`else
            state_d = S_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
`endif
          end
        end
      end
`ifdef BRAM_READER_CHECKSUM_EN
      S_CSUM: begin
        if (m_ready) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Shared word fetch used by LOAD and back-to-back SEND
    if (capture) begin
      state_d = S_SEND;
      data_d  = bram_data;
      valid_d = 1'b1;
      ptr_d   = ptr_q + AW'(1);
      rem_d   = rem_q - RW'(1);
      csum_d  = csum_q ^ bram_data;
`ifdef BRAM_READER_CHECKSUM_EN
      last_d  = 1'b0;
`else
      last_d  = (rem_q == RW'(1));
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bram_addr = ptr_q;
  assign m_data    = data_q;
  assign m_valid   = valid_q;
  assign m_last    = last_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_bram_frame_reader.sv
// Directed bench for bram_frame_reader; covers the checksum beat when
// BRAM_READER_CHECKSUM_EN is defined.
module tb_bram_frame_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] start_addr;
  logic [6:0] length;
  logic       busy;
  logic       done;
  logic [5:0] bram_addr;
  logic [7:0] bram_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;

  logic [7:0] mem [0:63];
  assign bram_data = mem[bram_addr];

  bram_frame_reader #(.ADDRESS_WIDTH(6), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .bram_addr(bram_addr),
    .bram_data(bram_data), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic [8:0] beats[$];
  int beat_cyc[$];
  logic [8:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes and done pulses observed mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) begin
        beats.push_back({m_last, m_data});
        beat_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_mon();
    beats.delete();
    beat_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic fill_exp(input int a, input int l);
    logic [7:0] d;
    logic [7:0] x;
    x = 8'h00;
    exp_q.delete();
    for (int i = 0; i < l; i++) begin
      d = mem[(a + i) % 64];
      x = x ^ d;
`ifdef BRAM_READER_CHECKSUM_EN
      exp_q.push_back({1'b0, d});
`else
      exp_q.push_back({(i == l - 1), d});
`endif
    end
`ifdef BRAM_READER_CHECKSUM_EN
    exp_q.push_back({1'b1, x});
`endif
  endtask

  task automatic start_frame(input logic [5:0] a, input logic [6:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    start_addr = a;
    length = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start_addr = '0;
    length = '0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, m_valid, m_last} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0000",
               {busy, done, m_valid, m_last});
    end
    checks++;
    if (m_data !== 8'h00 || bram_addr !== 6'd0) begin
      errors++;
      $display("FAIL reset_dp: data=%h addr=%0d want 00/0",
               m_data, bram_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    clear_mon();
    m_ready = 1'b1;
    start_frame(6'd4, 7'd3);
    wait_done(30, ok);
    fill_exp(4, 3);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done: got timeout want done");
    end
    checks++;
    if (beats.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL basic_count: got %0d want %0d",
               beats.size(), exp_q.size());
    end else begin
      for (int i = 0; i < beats.size(); i++) begin
        checks++;
        if (beats[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL basic_beat%0d: got %h want %h",
                   i, beats[i], exp_q[i]);
        end
      end
      for (int i = 1; i < beat_cyc.size(); i++) begin
        checks++;
        if (beat_cyc[i] - beat_cyc[i-1] !== 1) begin
          errors++;
          $display("FAIL basic_b2b%0d: gap %0d want 1",
                   i, beat_cyc[i] - beat_cyc[i-1]);
        end
      end
      n = beat_cyc.size();
      checks++;
      if (n > 0 && done_cyc !== beat_cyc[n-1] + 1) begin
        errors++;
        $display("FAIL basic_done_lat: got %0d want %0d",
                 done_cyc - beat_cyc[n-1], 1);
      end
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: got cnt=%0d busy=%b want 1/0",
               done_cnt, busy);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_mon();
    m_ready = 1'b1;
    start_frame(6'd62, 7'd4);
    checks++;
    if (bram_addr !== 6'd62) begin
      errors++;
      $display("FAIL wrap_addr0: got %0d want 62", bram_addr);
    end
    wait_done(30, ok);
    fill_exp(62, 4);
    checks++;
    if (!ok || beats.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL wrap_count: got ok=%b n=%0d want 1/%0d",
               ok, beats.size(), exp_q.size());
    end else begin
      for (int i = 0; i < beats.size(); i++) begin
        checks++;
        if (beats[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wrap_beat%0d: got %h want %h",
                   i, beats[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [7:0] hold;
    clear_mon();
    m_ready = 1'b0;
    start_frame(6'd20, 7'd2);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (m_valid) ok = 1'b1;
    end
    checks++;
    if (!ok || m_data !== 8'h24) begin
      errors++;
      $display("FAIL bp_first: got v=%b d=%h want 1/24",
               ok, m_data);
    end
    hold = m_data;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = (i == 1);
      start_addr = 6'd0;
      length = 7'd5;
      checks++;
      if (m_data !== hold || m_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h/%b want %h/1",
                 i, m_data, m_valid, hold);
      end
    end
    start = 1'b0;
    m_ready = 1'b1;
    wait_done(20, ok);
    repeat (6) @(posedge clk);
    #1;
    fill_exp(20, 2);
    checks++;
    if (!ok || beats.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL bp_count: got ok=%b n=%0d want 1/%0d",
               ok, beats.size(), exp_q.size());
    end else begin
      for (int i = 0; i < beats.size(); i++) begin
        checks++;
        if (beats[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_beat%0d: got %h want %h",
                   i, beats[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_ignore: got cnt=%0d busy=%b want 1/0",
               done_cnt, busy);
    end
  endtask

  task automatic test_len0();
    bit ok;
    int s;
    clear_mon();
    m_ready = 1'b1;
    start_frame(6'd9, 7'd0);
    s = cyc;
    wait_done(10, ok);
    repeat (3) @(posedge clk);
    #1;
    fill_exp(9, 0);
    checks++;
    if (!ok || done_cnt !== 1 || done_cyc - s > 1) begin
      errors++;
      $display("FAIL len0_done: got ok=%b cnt=%0d lat=%0d want 1/1/<=1",
               ok, done_cnt, done_cyc - s);
    end
    checks++;
    if (beats.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL len0_count: got %0d want %0d",
               beats.size(), exp_q.size());
    end else if (exp_q.size() > 0) begin
      checks++;
      if (beats[0] !== exp_q[0]) begin
        errors++;
        $display("FAIL len0_beat: got %h want %h", beats[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_len64();
    bit ok;
    bit seen [64];
    int bad;
    int missing;
    clear_mon();
    m_ready = 1'b1;
    start_frame(6'd5, 7'd64);
    wait_done(200, ok);
    fill_exp(5, 64);
    checks++;
    if (!ok || beats.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL len64_count: got ok=%b n=%0d want 1/%0d",
               ok, beats.size(), exp_q.size());
    end else begin
      bad = 0;
      for (int i = 0; i < 64; i++) seen[i] = 1'b0;
      for (int i = 0; i < beats.size(); i++) begin
        if (beats[i] !== exp_q[i]) bad++;
        if (i < 64) seen[beats[i][5:0] - 6'h10] = 1'b1;
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL len64_data: got %0d bad beats want 0", bad);
      end
      missing = 0;
      for (int i = 0; i < 64; i++) if (!seen[i]) missing++;
      checks++;
      if (missing !== 0) begin
        errors++;
        $display("FAIL len64_cover: got %0d unread want 0", missing);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int d0;
    clear_mon();
    m_ready = 1'b1;
    start_frame(6'd0, 7'd30);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, m_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid: got %b want 000", {busy, done, m_valid});
    end
    rst_n = 1'b1;
    d0 = done_cnt;
    beats.delete();
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== d0 || done_cnt !== 0 || beats.size() !== 0) begin
      errors++;
      $display("FAIL rst_abort: got done=%0d beats=%0d want 0/0",
               done_cnt, beats.size());
    end
  endtask

`ifdef BRAM_READER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    logic [8:0] want [4];
    want[0] = 9'h0A5;
    want[1] = 9'h00F;
    want[2] = 9'h0F0;
    want[3] = 9'h15A;
    mem[10] = 8'hA5;
    mem[11] = 8'h0F;
    mem[12] = 8'hF0;
    clear_mon();
    m_ready = 1'b1;
    start_frame(6'd10, 7'd3);
    wait_done(30, ok);
    checks++;
    if (!ok || beats.size() !== 4) begin
      errors++;
      $display("FAIL csum_count: got ok=%b n=%0d want 1/4",
               ok, beats.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (beats[i] !== want[i]) begin
          errors++;
          $display("FAIL csum_beat%0d: got %h want %h",
                   i, beats[i], want[i]);
        end
      end
    end
    clear_mon();
    start_frame(6'd10, 7'd0);
    wait_done(10, ok);
    checks++;
    if (!ok || beats.size() !== 1 || beats[0] !== 9'h100) begin
      errors++;
      $display("FAIL csum_len0: got ok=%b n=%0d want 1/1 beat 100",
               ok, beats.size());
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 16);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_len64();
    test_reset_midframe();
`ifdef BRAM_READER_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
